// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the WM8731 DAC path: mono samples in on valid/ready,
// serialised MSB-first onto both slots, timed by codec-mastered BCLK/DACLRCK.
module i2s_dac_tx #(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] sample_data,
  input  logic         sample_valid,
  output logic         sample_ready,
  input  logic         aud_bclk,
  input  logic         aud_daclrck,
  output logic         aud_dacdat,
  output logic         frame_start,
  output logic         underrun
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(W);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] bclkSync_q;
  logic [SYNC_STAGES-1:0] lrckSync_q;
  logic                   bclkPrev_q;
  logic                   lrck_q, lrck_d;

  logic [W-1:0]  holdData_q, holdData_d;
  logic          holdFull_q, holdFull_d;
  logic [W-1:0]  word_q, word_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] bitCnt_q, bitCnt_d;
  logic          dacdat_q, dacdat_d;
  logic          frameStart_q, frameStart_d;
  logic          underrun_q, underrun_d;

  logic bclkSync;
  logic lrckSync;
  logic bclkFall;
  logic boundary;
  logic leftEdge;
  logic rightEdge;
  logic accept;

  // Both codec clocks pass through identical chains so DACLRCK stays aligned with BCLK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclkSync_q <= '0;
      lrckSync_q <= '0;
      bclkPrev_q <= 1'b0;
    end else begin
      bclkSync_q[0] <= aud_bclk;
      lrckSync_q[0] <= aud_daclrck;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bclkSync_q[i] <= bclkSync_q[i-1];
        lrckSync_q[i] <= lrckSync_q[i-1];
      end
      bclkPrev_q <= bclkSync;
    end
  end

  assign bclkSync  = bclkSync_q[SYNC_STAGES-1];
  assign lrckSync  = lrckSync_q[SYNC_STAGES-1];
  assign bclkFall  = bclkPrev_q & ~bclkSync;
  assign boundary  = bclkFall && (lrckSync != lrck_q);
  assign leftEdge  = boundary && !lrckSync;
  assign rightEdge = boundary && lrckSync && (state_q == ST_LOCKED);
  assign accept    = sample_valid && !holdFull_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      lrck_q       <= 1'b0;
      holdData_q   <= '0;
      holdFull_q   <= 1'b0;
      word_q       <= '0;
      shreg_q      <= '0;
      bitCnt_q     <= '0;
      dacdat_q     <= 1'b0;
      frameStart_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lrck_q       <= lrck_d;
      holdData_q   <= holdData_d;
      holdFull_q   <= holdFull_d;
      word_q       <= word_d;
      shreg_q      <= shreg_d;
      bitCnt_q     <= bitCnt_d;
      dacdat_q     <= dacdat_d;
      frameStart_q <= frameStart_d;
      underrun_q   <= underrun_d;
    end
  end

  // A left boundary samples the holder as it was before this cycle's accept,
  // so a coincident write lands in the next frame instead of this one.
  always_comb begin
    state_d      = state_q;
    lrck_d       = lrck_q;
    holdData_d   = holdData_q;
    holdFull_d   = holdFull_q;
    word_d       = word_q;
    shreg_d      = shreg_q;
    bitCnt_d     = bitCnt_q;
    dacdat_d     = dacdat_q;
    frameStart_d = 1'b0;
    underrun_d   = 1'b0;

    if (accept) begin
      holdData_d = sample_data;
      holdFull_d = 1'b1;
    end

    if (bclkFall) begin
      lrck_d = lrckSync;
      if (leftEdge) begin
        state_d      = ST_LOCKED;
        frameStart_d = 1'b1;
        if (holdFull_q) begin
          word_d     = holdData_q;
          holdFull_d = 1'b0;
        end else begin
          word_d     = '0;
          underrun_d = 1'b1;
        end
        shreg_d  = word_d;
        bitCnt_d = '0;
        dacdat_d = 1'b0;
      end else if (state_q == ST_IDLE) begin
        dacdat_d = 1'b0;
      end else if (rightEdge) begin
        shreg_d  = word_q;
        bitCnt_d = '0;
        dacdat_d = 1'b0;
      end else if (bitCnt_q < BIT_LAST) begin
        dacdat_d = shreg_q[W-1];
        shreg_d  = shreg_q << 1;
        bitCnt_d = bitCnt_q + CW'(1);
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  assign sample_ready = ~holdFull_q;
  assign aud_dacdat   = dacdat_q;
  assign frame_start  = frameStart_q;
  assign underrun     = underrun_q;

endmodule
